// File: rtl/palette_arbiter_if.sv
// Video, config and RAM-side signals of palette_arbiter, grouped as one bus.
// The arbiter uses the slave modport; the environment driving it uses master.
interface palette_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 12
);
    logic              iVidReq;
    logic [ADDR_W-1:0] iVidAddr;
    logic              oVidValid;
    logic [DATA_W-1:0] oVidData;
    logic              iCfgReq;
    logic              iCfgWe;
    logic [ADDR_W-1:0] iCfgAddr;
    logic [DATA_W-1:0] iCfgWdata;
    logic              oCfgAck;
    logic [DATA_W-1:0] oCfgRdata;
    logic              oCfgStarve;
    logic              oMemEn;
    logic              oMemWe;
    logic [ADDR_W-1:0] oMemAddr;
    logic [DATA_W-1:0] oMemWdata;
    logic [DATA_W-1:0] iMemRdata;

    modport slave (
        input  iVidReq, iVidAddr, iCfgReq, iCfgWe, iCfgAddr, iCfgWdata, iMemRdata,
        output oVidValid, oVidData, oCfgAck, oCfgRdata, oCfgStarve,
        output oMemEn, oMemWe, oMemAddr, oMemWdata
    );

    modport master (
        output iVidReq, iVidAddr, iCfgReq, iCfgWe, iCfgAddr, iCfgWdata, iMemRdata,
        input  oVidValid, oVidData, oCfgAck, oCfgRdata, oCfgStarve,
        input  oMemEn, oMemWe, oMemAddr, oMemWdata
    );
endinterface

// File: rtl/palette_arbiter.sv
// Shares a single-port palette RAM between pipelined video reads (always win)
// and a req/ack configuration port that is served only in video-idle cycles.
module palette_arbiter #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic             iClk,
    input  logic             iRst_n,
    palette_arbiter_if.slave bus
);
    typedef enum logic [1:0] {CfgIdle, CfgRdWait, CfgAck} cfg_state_e;
    typedef enum logic [1:0] {TagNone, TagVid, TagCfg} tag_e;

    cfg_state_e        state_q, state_d;
    tag_e              tag1_q, tag1_d, tag2_q, tag2_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic              cfg_ack_q, cfg_ack_d;
    logic [DATA_W-1:0] cfg_rdata_q, cfg_rdata_d;
    logic [7:0]        stall_q, stall_d;
    logic              starve_q, starve_d;
    logic              vid_gnt, cfg_gnt;

    always_comb begin
        vid_gnt = bus.iVidReq;
        cfg_gnt = ~bus.iVidReq & bus.iCfgReq & (state_q == CfgIdle);

        mem_en_d    = vid_gnt | cfg_gnt;
        mem_we_d    = cfg_gnt & bus.iCfgWe;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (vid_gnt) begin
            mem_addr_d = bus.iVidAddr;
        end else if (cfg_gnt) begin
            mem_addr_d  = bus.iCfgAddr;
            mem_wdata_d = bus.iCfgWdata;
        end

        // Tag follows each read until the RAM data it belongs to arrives
        tag1_d = TagNone;
        if (vid_gnt) begin
            tag1_d = TagVid;
        end else if (cfg_gnt && !bus.iCfgWe) begin
            tag1_d = TagCfg;
        end
        tag2_d = tag1_q;

        vid_valid_d = (tag2_q == TagVid);
        vid_data_d  = vid_valid_d ? bus.iMemRdata : vid_data_q;

        state_d     = state_q;
        cfg_ack_d   = 1'b0;
        cfg_rdata_d = cfg_rdata_q;
        unique case (state_q)
            CfgIdle: begin
                if (cfg_gnt) begin
                    if (bus.iCfgWe) begin
                        state_d   = CfgAck;
                        cfg_ack_d = 1'b1;
                    end else begin
                        state_d = CfgRdWait;
                    end
                end
            end
            CfgRdWait: begin
                if (tag2_q == TagCfg) begin
                    state_d     = CfgAck;
                    cfg_ack_d   = 1'b1;
                    cfg_rdata_d = bus.iMemRdata;
                end
            end
            CfgAck:  state_d = CfgIdle;
            default: state_d = CfgIdle;
        endcase

        stall_d = stall_q;
        if (cfg_gnt || !bus.iCfgReq) begin
            stall_d = 8'd0;
        end else if (state_q == CfgIdle && stall_q != 8'd255) begin
            stall_d = stall_q + 8'd1;
        end
        starve_d = (stall_q >= 8'(MAX_WAIT));
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= CfgIdle;
            tag1_q      <= TagNone;
            tag2_q      <= TagNone;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
            cfg_ack_q   <= 1'b0;
            cfg_rdata_q <= '0;
            stall_q     <= 8'd0;
            starve_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            vid_valid_q <= vid_valid_d;
            vid_data_q  <= vid_data_d;
            cfg_ack_q   <= cfg_ack_d;
            cfg_rdata_q <= cfg_rdata_d;
            stall_q     <= stall_d;
            starve_q    <= starve_d;
        end
    end

    assign bus.oMemEn     = mem_en_q;
    assign bus.oMemWe     = mem_we_q;
    assign bus.oMemAddr   = mem_addr_q;
    assign bus.oMemWdata  = mem_wdata_q;
    assign bus.oVidValid  = vid_valid_q;
    assign bus.oVidData   = vid_data_q;
    assign bus.oCfgAck    = cfg_ack_q;
    assign bus.oCfgRdata  = cfg_rdata_q;
    assign bus.oCfgStarve = starve_q;
endmodule
